fp_mul_norm_round: RTL and testbench



---
 rtl/fp_mul_norm_round_pkg.sv | 30 +++
 rtl/fp_mul_norm_round_if.sv | 28 ++
 rtl/fp_mul_norm_round_round_pack.sv | 59 +++++
 rtl/fp_mul_norm_round.sv | 98 +++++++++
 tb/tb_fp_mul_norm_round.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_norm_round_pkg.sv
// Shared widths and payload types for the FPU multiply normalise/round path.
package fpu_pkg;

    localparam int unsigned MANT_W  = 12;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned BIAS    = 127;

    localparam int unsigned PROD_W  = 2 * MANT_W;
    localparam int unsigned EXT_W   = EXP_W + 2;
    localparam int unsigned FRAC_W  = MANT_W - 1;
    localparam int unsigned RES_W   = 1 + EXP_W + FRAC_W;
    // All-ones biased exponent: first value that must saturate to infinity
    localparam int unsigned EXP_MAX = 2 * BIAS + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    typedef struct packed {
        logic                    sign;
        logic [MANT_W-1:0]       sig;
        logic                    guard;
        logic                    sticky;
        logic signed [EXT_W-1:0] e;
        logic                    zero;
    } norm_t;

endpackage

// File: rtl/fp_mul_norm_round_if.sv
// Valid/ready bus between multiplier_12bit, this block and its consumer.
interface fp_mul_norm_round_if
    import fpu_pkg::*;
();

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [EXT_W-1:0] in_exp;
    logic [PROD_W-1:0]       in_prod;

    logic                    out_valid;
    logic                    out_ready;
    fp_t                     out_result;
    logic                    out_ovf;
    logic                    out_unf;

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf
    );

    modport master (
        output in_valid, in_sign, in_exp, in_prod, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf
    );

endinterface

// File: rtl/fp_mul_norm_round_round_pack.sv
// Stage-2 combinational rounding, exception detection and packing.
// FPMUL_RNE_EN selects round-to-nearest-even; otherwise the significand is truncated.
module fp_round_pack
    import fpu_pkg::*;
(
    input  norm_t n,
    output fp_t   result,
    output logic  ovf,
    output logic  unf
);

    logic              inc;
    logic [MANT_W:0]   sig_r;
    logic [EXT_W:0]    e_r;
    logic [FRAC_W-1:0] frac;

    // Rounding increment decision
`ifdef FPMUL_RNE_EN
    assign inc = n.guard & (n.sticky | n.sig[0]);
`else
    logic unused_gs;
    assign unused_gs = n.guard ^ n.sticky;
    assign inc       = 1'b0;
`endif

    assign sig_r = {1'b0, n.sig} + (MANT_W+1)'(inc);

    // Carry fix-up, then zero / overflow / underflow priority and packing
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unf    = 1'b0;
        e_r    = {n.e[EXT_W-1], n.e};
        frac   = sig_r[FRAC_W-1:0];

        if (sig_r[MANT_W]) begin
            e_r  = e_r + (EXT_W+1)'(1);
            frac = '0;
        end

        result.sign = n.sign;
        if (n.zero) begin
            result.exp  = '0;
            result.frac = '0;
        end else if (!e_r[EXT_W] && (e_r[EXT_W-1:0] >= EXT_W'(EXP_MAX))) begin
            result.exp  = '1;
            result.frac = '0;
            ovf         = 1'b1;
        end else if (e_r[EXT_W] || (e_r == '0)) begin
            result.exp  = '0;
            result.frac = '0;
            unf         = 1'b1;
        end else begin
            result.exp  = e_r[EXP_W-1:0];
            result.frac = frac;
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage valid/ready pipeline: stage 1 normalises the significand product,
// stage 2 rounds and packs {sign, exp, frac} with overflow/underflow flags.
// Optional macro FPMUL_RNE_EN enables round-to-nearest-even (default: truncate).
module fp_mul_norm_round
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp_mul_norm_round_if.slave bus
);

    // Largest positive pre-normalisation exponent; incrementing it would wrap negative
    localparam logic [EXT_W-1:0] EXP_TOP = {1'b0, {(EXT_W-1){1'b1}}};

    norm_t s1_d;
    norm_t s1_q;
    logic  s1_valid;
    logic  s2_valid;
    logic  s2_can_accept;
    logic  in_ready_c;

    fp_t   rp_result;
    logic  rp_ovf;
    logic  rp_unf;
    fp_t   result_q;
    logic  ovf_q;
    logic  unf_q;

    assign s2_can_accept = !s2_valid || bus.out_ready;
    assign in_ready_c    = !s1_valid || s2_can_accept;

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = s2_valid;
    assign bus.out_result = result_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_unf    = unf_q;

    // Stage-1 normalisation: pick the significand window by the product MSB
    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_sign;
        s1_d.zero = (bus.in_prod == '0);
        if (bus.in_prod[PROD_W-1]) begin
            s1_d.sig = bus.in_prod[PROD_W-1 -: MANT_W];
            s1_d.e   = (bus.in_exp == EXP_TOP) ? bus.in_exp
                                               : bus.in_exp + EXT_W'(1);
`ifdef FPMUL_RNE_EN
            s1_d.guard  = bus.in_prod[MANT_W-1];
            s1_d.sticky = |bus.in_prod[MANT_W-2:0];
`endif
        end else begin
            s1_d.sig = bus.in_prod[PROD_W-2 -: MANT_W];
            s1_d.e   = bus.in_exp;
`ifdef FPMUL_RNE_EN
            s1_d.guard  = bus.in_prod[MANT_W-2];
            s1_d.sticky = |bus.in_prod[MANT_W-3:0];
`endif
        end
    end

    // Stage-1 register: loads whenever the stage is empty or draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    fp_round_pack u_round_pack (
        .n      (s1_q),
        .result (rp_result),
        .ovf    (rp_ovf),
        .unf    (rp_unf)
    );

    // Stage-2 register: holds the packed result stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (s2_can_accept) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_q <= rp_result;
                ovf_q    <= rp_ovf;
                unf_q    <= rp_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Scoreboard bench for fp_mul_norm_round: directed cases, backpressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_fp_mul_norm_round;
    import fpu_pkg::*;

    typedef struct {
        logic [19:0] res;
        logic        ovf;
        logic        unf;
        int          acc_cyc;
        bit          lat_chk;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   stall_until = 0;
    bit   rand_sink = 1'b0;
    sb_t  sbq[$];

    fp_mul_norm_round_if bus ();

    fp_mul_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic sb_t mk(input logic [19:0] res, input bit ovf, input bit unf);
        sb_t x;
        x.res = res; x.ovf = ovf; x.unf = unf; x.acc_cyc = 0; x.lat_chk = 1'b0;
        return x;
    endfunction

    // Reference: value-level normalise, nearest-even (or truncate), then range classify
    function automatic sb_t model(input bit s, input int e, input int p);
        int          sig, rem, half, ee;
        logic [31:0] sv, ev;
        if (p == 0) return mk({s, 19'h0}, 1'b0, 1'b0);
        if (p >= (1 << 23)) begin
            sig = p >> 12; rem = p % (1 << 12); half = 1 << 11; ee = e + 1;
        end else begin
            sig = p >> 11; rem = p % (1 << 11); half = 1 << 10; ee = e;
        end
`ifdef FPMUL_RNE_EN
        if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
`else
        if (rem < 0 || half < 0) sig = 0;
`endif
        if (sig == (1 << 12)) begin
            sig = 1 << 11;
            ee  = ee + 1;
        end
        if (ee >= 255) return mk({s, 8'hFF, 11'h0}, 1'b1, 1'b0);
        if (ee <= 0)   return mk({s, 19'h0}, 1'b0, 1'b1);
        sv = sig; ev = ee;
        return mk({s, ev[7:0], sv[10:0]}, 1'b0, 1'b0);
    endfunction

    // Present one input, wait (bounded) for acceptance, log the expected response
    task automatic send(input bit s, input int e, input logic [23:0] p, input sb_t want,
                        input bit lat, output int waits);
        sb_t x;
        bit  ok;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = 10'(e); bus.in_prod = p;
        waits = 0;
        ok    = 1'b0;
        forever begin
            #1;
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
            if (waits > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at %b, expected 1", bus.in_ready);
                bus.in_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            x = want;
            x.acc_cyc = cyc;
            x.lat_chk = lat;
            sbq.push_back(x);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        #2;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: drives out_ready, checks hold stability and pops the scoreboard on transfer
    initial begin : monitor
        sb_t         x;
        bit          holding;
        logic [21:0] held;
        holding = 1'b0;
        held    = '0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (cyc < stall_until) bus.out_ready = 1'b0;
            else if (rand_sink)    bus.out_ready = 1'($urandom_range(0, 1));
            else                   bus.out_ready = 1'b1;
            #1;
            if (rst) begin
                holding = 1'b0;
                continue;
            end
            if (holding) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_stable", 32'({bus.out_result, bus.out_ovf, bus.out_unf}), 32'(held));
            end
            holding = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no output", bus.out_result);
                    end else begin
                        x = sbq.pop_front();
                        chk("result", 32'(bus.out_result), 32'(x.res));
                        chk("ovf", 32'(bus.out_ovf), 32'(x.ovf));
                        chk("unf", 32'(bus.out_unf), 32'(x.unf));
                        if (x.lat_chk) chk("latency", 32'(cyc - x.acc_cyc), 32'd2);
                    end
                end else begin
                    holding = 1'b1;
                    held    = {bus.out_result, bus.out_ovf, bus.out_unf};
                end
            end
        end
    end

    initial begin : main
        int          w0, w1, w2, w3;
        int          e, r;
        bit          s;
        logic [23:0] p;

        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_prod = '0;
        rst = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.out_result), 32'd0);
        chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_unf", 32'(bus.out_unf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed cases, back to back with the sink always ready
        send(1'b0, 127, 24'h851092, mk({1'b0, 8'h80, 11'h051}, 1'b0, 1'b0), 1'b1, w0);
        send(1'b1, 127, 24'h400000, mk({1'b1, 8'h7F, 11'h000}, 1'b0, 1'b0), 1'b1, w0);
`ifdef FPMUL_RNE_EN
        send(1'b0, 100, 24'h7FFC00, mk({1'b0, 8'h65, 11'h000}, 1'b0, 1'b0), 1'b1, w0);
`else
        send(1'b0, 100, 24'h7FFC00, mk({1'b0, 8'h64, 11'h7FF}, 1'b0, 1'b0), 1'b1, w0);
`endif
        send(1'b0, 254, 24'h800000, mk({1'b0, 8'hFF, 11'h000}, 1'b1, 1'b0), 1'b1, w0);
        send(1'b0, 0,   24'h400000, mk(20'h0, 1'b0, 1'b1), 1'b1, w0);
        send(1'b0, 511, 24'h800000, mk({1'b0, 8'hFF, 11'h000}, 1'b1, 1'b0), 1'b1, w0);
        send(1'b1, -512, 24'h7FFC00, mk({1'b1, 19'h0}, 1'b0, 1'b1), 1'b1, w0);
        send(1'b1, -5,  24'h000000, mk({1'b1, 19'h0}, 1'b0, 1'b0), 1'b1, w0);
        idle(1);
        drain();

        // Backpressure: sink stalls for three cycles while four inputs stream in
        stall_until = cyc + 4;
        send(1'b0, 130, 24'hA00000, model(1'b0, 130, 24'hA00000), 1'b0, w0);
        send(1'b1, 120, 24'h5A5A5A, model(1'b1, 120, 24'h5A5A5A), 1'b0, w1);
        send(1'b0, 1,   24'h400400, model(1'b0, 1,   24'h400400), 1'b0, w2);
        send(1'b1, 253, 24'hFFFFFF, model(1'b1, 253, 24'hFFFFFF), 1'b0, w3);
        idle(1);
        chk("bp_accept0_waits", 32'(w0), 32'd0);
        chk("bp_accept1_waits", 32'(w1), 32'd0);
        chk("bp_third_stalled", 32'(w2 > 0), 32'd1);
        drain();

        // Reset with both stages full
        stall_until = cyc + 1000;
        send(1'b0, 127, 24'h851092, mk({1'b0, 8'h80, 11'h051}, 1'b0, 1'b0), 1'b0, w0);
        send(1'b1, 127, 24'h400000, mk({1'b1, 8'h7F, 11'h000}, 1'b0, 1'b0), 1'b0, w0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_result", 32'(bus.out_result), 32'd0);
        chk("mid_rst_flags", 32'({bus.out_ovf, bus.out_unf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_until = 0;
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        send(1'b0, 127, 24'h851092, mk({1'b0, 8'h80, 11'h051}, 1'b0, 1'b0), 1'b1, w0);
        idle(1);
        drain();

        // Randomized traffic with a randomly stalling sink
        rand_sink = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 14)      p = 24'($urandom_range(2048, 4095) * $urandom_range(2048, 4095));
            else if (r < 18) p = 24'($urandom);
            else             p = 24'h0;
            r = int'($urandom_range(0, 9));
            if (r < 5)      e = 100 + int'($urandom_range(0, 60));
            else if (r < 7) e = int'($urandom_range(0, 6)) - 3;
            else if (r < 9) e = 250 + int'($urandom_range(0, 8));
            else            e = int'($urandom_range(0, 1023)) - 512;
            s = 1'($urandom_range(0, 1));
            send(s, e, p, model(s, e, int'(p)), 1'b0, w0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        rand_sink = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
